// File: rtl/seq_divider_32bit.sv
// seq_divider_32bit: restoring shift-subtract DIV/DIVU, one quotient bit per cycle.
// Define DIV_ZERO_DETECT_EN to short-circuit zero divisors in one cycle and flag div_zero.
module seq_divider_32bit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);
    typedef enum logic [1:0] {IDLE, RUN, FIX, ZERO} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
    logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d, done_q, done_d;
    logic [WIDTH:0]   trial;
`ifdef DIV_ZERO_DETECT_EN
    logic             div_zero_q, div_zero_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        done_d      = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
        div_zero_d  = div_zero_q;
`endif
        // rem < dvs always holds, so bit WIDTH of the difference is exactly the borrow
        trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
        case (state_q)
            IDLE: if (start) begin
                quo_d   = (is_signed && dividend[WIDTH-1]) ? ~dividend + WIDTH'(1) : dividend;
                dvs_d   = (is_signed && divisor[WIDTH-1]) ? ~divisor + WIDTH'(1) : divisor;
                q_neg_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                r_neg_d = is_signed & dividend[WIDTH-1];
                rem_d   = '0;
                cnt_d   = '0;
                state_d = RUN;
`ifdef DIV_ZERO_DETECT_EN
                div_zero_d = 1'b0;
                if (divisor == '0) begin
                    rem_d   = dividend;
                    state_d = ZERO;
                end
`endif
            end
            RUN: begin
                quo_d   = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                rem_d   = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = (cnt_q == CNT_W'(WIDTH - 1)) ? FIX : RUN;
            end
            FIX: begin
                quotient_d  = q_neg_q ? ~quo_q + WIDTH'(1) : quo_q;
                remainder_d = r_neg_q ? ~rem_q + WIDTH'(1) : rem_q;
                done_d      = 1'b1;
                state_d     = IDLE;
            end
`ifdef DIV_ZERO_DETECT_EN
            ZERO: begin
                quotient_d  = '1;
                remainder_d = rem_q;
                div_zero_d  = 1'b1;
                done_d      = 1'b1;
                state_d     = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
        end
    end

`ifdef DIV_ZERO_DETECT_EN
    always_ff @(posedge clk) begin
        if (reset) div_zero_q <= 1'b0;
        else div_zero_q <= div_zero_d;
    end
    assign div_zero = div_zero_q;
`else
    assign div_zero = 1'b0;
`endif

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
endmodule

// File: tb/tb_seq_divider_32bit.sv
// tb_seq_divider_32bit: vector table + scoreboard queue for seq_divider_32bit, with abort/restart corner sequences.
module tb_seq_divider_32bit;
    logic        clk = 1'b0;
    logic        reset, start, is_signed, busy, done, div_zero;
    logic [31:0] dividend, divisor, quotient, remainder;

`ifdef DIV_ZERO_DETECT_EN
    localparam bit ZD = 1'b1;
`else
    localparam bit ZD = 1'b0;
`endif

    typedef struct {
        logic        s;
        logic [31:0] a, b, q, r;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[12];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    seq_divider_32bit dut (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic s, logic [31:0] a, logic [31:0] b, logic [31:0] q, logic [31:0] r);
        vec_t v;
        v.s = s; v.a = a; v.b = b; v.q = q; v.r = r;
        v.dz  = ZD && (b == 32'd0);
        v.lat = v.dz ? 1 : 33;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input bit push);
        start = 1'b1; is_signed = v.s; dividend = v.a; divisor = v.b;
        if (push) sb.push_back(v);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; is_signed = 1'($urandom); dividend = $urandom; divisor = $urandom;
    endtask

    task automatic wait_done(input int poke_at);
        int   lat = 0;
        vec_t v;
        while (!done && lat < 200) begin
            chk("busy_inflight", 32'(busy), 32'd1);
            start = (lat == poke_at);
            if (lat == poke_at) begin
                is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done expected done within 200 cycles");
        end else if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard: got done expected no done (queue empty)");
        end else begin
            v = sb.pop_front();
            chk("latency", 32'(lat), 32'(v.lat));
            chk("busy_at_done", 32'(busy), 32'd0);
            chk("quotient", quotient, v.q);
            chk("remainder", remainder, v.r);
            chk("div_zero", 32'(div_zero), 32'(v.dz));
        end
    endtask

    initial begin
        int dcount;
        vecs[0]  = mk(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        vecs[1]  = mk(1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE);
        vecs[2]  = mk(1'b1, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2);
        vecs[3]  = mk(1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0);
        vecs[4]  = mk(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);
        vecs[5]  = mk(1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5);
        vecs[6]  = mk(1'b1, 32'hFFFFFFF9, 32'd0, ZD ? 32'hFFFFFFFF : 32'd1, 32'hFFFFFFF9);
        vecs[7]  = mk(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE);
        vecs[8]  = mk(1'b0, 32'hFFFFFFFF, 32'h80000001, 32'd1, 32'h7FFFFFFE);
        vecs[9]  = mk(1'b0, 32'd12345678, 32'd1000, 32'd12345, 32'd678);
        vecs[10] = mk(1'b0, 32'd3, 32'd10, 32'd0, 32'd3);
        vecs[11] = mk(1'b1, 32'h7FFFFFFF, 32'd2, 32'h3FFFFFFF, 32'd1);

        reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        chk("rst_div_zero", 32'(div_zero), 32'd0);

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i], 1'b1);
            wait_done(-1);
            @(negedge clk);
            chk("done_single_pulse", 32'(done), 32'd0);
            chk("quotient_hold", quotient, vecs[i].q);
            chk("remainder_hold", remainder, vecs[i].r);
        end

        // start pulsed mid-operation must be ignored
        drive(vecs[0], 1'b1);
        wait_done(10);
        @(negedge clk);

        // start in the done cycle is accepted
        drive(vecs[1], 1'b1);
        wait_done(-1);
        drive(vecs[2], 1'b1);
        wait_done(-1);
        @(negedge clk);

        // reset mid-operation aborts without a done
        drive(vecs[9], 1'b0);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_quotient", quotient, 32'd0);
        chk("abort_remainder", remainder, 32'd0);
        dcount = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("abort_no_done", 32'(dcount), 32'd0);
        drive(vecs[11], 1'b1);
        wait_done(-1);
        @(negedge clk);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
